// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: issue packets from register_file, CDB broadcasts,
// dispatch to the reservation stations, and in-order commit.
// slave = the reorder buffer itself, master = its surrounding pipeline.
interface reorder_buffer_if #(
  parameter int ROB_BIT = 4,
  parameter int REG_BIT = 5,
  parameter int DAT_W   = 32,
  parameter int OP_W    = 6
);
  logic               alloc_ready_o;
  logic [ROB_BIT-1:0] alloc_id_o;
  logic               rf_en_i;
  logic [ROB_BIT-1:0] rf_qd_i;
  logic [REG_BIT-1:0] rf_rd_i;
  logic [ROB_BIT-1:0] rf_qj_i;
  logic [ROB_BIT-1:0] rf_qk_i;
  logic [DAT_W-1:0]   rf_vj_i;
  logic [DAT_W-1:0]   rf_vk_i;
  logic [OP_W-1:0]    rf_op_i;
  logic [DAT_W-1:0]   rf_imm_i;
  logic               cdb_en_i;
  logic [ROB_BIT-1:0] cdb_q_i;
  logic [DAT_W-1:0]   cdb_v_i;
  logic               rs_en_o;
  logic [ROB_BIT-1:0] rs_qj_o;
  logic [ROB_BIT-1:0] rs_qk_o;
  logic [DAT_W-1:0]   rs_vj_o;
  logic [DAT_W-1:0]   rs_vk_o;
  logic [ROB_BIT-1:0] rs_qd_o;
  logic [OP_W-1:0]    rs_op_o;
  logic [DAT_W-1:0]   rs_imm_o;
  logic               rf_en_o;
  logic [REG_BIT-1:0] rf_rd_o;
  logic [ROB_BIT-1:0] rf_q_o;
  logic [DAT_W-1:0]   rf_v_o;

  modport slave (
    output alloc_ready_o, alloc_id_o,
    input  rf_en_i, rf_qd_i, rf_rd_i, rf_qj_i, rf_qk_i, rf_vj_i, rf_vk_i, rf_op_i, rf_imm_i,
    input  cdb_en_i, cdb_q_i, cdb_v_i,
    output rs_en_o, rs_qj_o, rs_qk_o, rs_vj_o, rs_vk_o, rs_qd_o, rs_op_o, rs_imm_o,
    output rf_en_o, rf_rd_o, rf_q_o, rf_v_o
  );

  modport master (
    input  alloc_ready_o, alloc_id_o,
    output rf_en_i, rf_qd_i, rf_rd_i, rf_qj_i, rf_qk_i, rf_vj_i, rf_vk_i, rf_op_i, rf_imm_i,
    output cdb_en_i, cdb_q_i, cdb_v_i,
    input  rs_en_o, rs_qj_o, rs_qk_o, rs_vj_o, rs_vk_o, rs_qd_o, rs_op_o, rs_imm_o,
    input  rf_en_o, rf_rd_o, rf_q_o, rf_v_o
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags 1..CAP (tag 0 = no dependency),
// resolves issue operands from its own entries or the CDB, dispatches to the
// RS one cycle later, records CDB results and commits in order.
// Optional feature: define ROB_FLUSH_EN to add the flush_i input.
module reorder_buffer #(
  parameter int ROB_BIT = 4,
  parameter int REG_BIT = 5,
  parameter int DAT_W   = 32,
  parameter int OP_W    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
`ifdef ROB_FLUSH_EN
  input  logic flush_i,
`endif
  reorder_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ROB_BIT;
  localparam logic [ROB_BIT-1:0] CAP_TAG = '1;
  localparam logic [ROB_BIT-1:0] ONE_TAG = ROB_BIT'(1);

  logic [ROB_BIT-1:0] head_reg, tail_reg, count_reg;
  logic [DEPTH-1:0]   valid_reg, ready_reg;
  logic [DEPTH-1:0]   valid_next, ready_next;
  logic [DAT_W-1:0]   value_mem [DEPTH];
  logic [REG_BIT-1:0] rd_mem [DEPTH];

  logic flush_fire, alloc_ready, alloc_fire, commit_fire, wb_fire;
  logic [ROB_BIT+DAT_W-1:0] res_j, res_k;

  function automatic logic [ROB_BIT-1:0] tag_inc(input logic [ROB_BIT-1:0] t);
    return (t == CAP_TAG) ? ONE_TAG : t + 1'b1;
  endfunction

  // Source operand resolution: own value, then stored result, then same-cycle CDB.
  function automatic logic [ROB_BIT+DAT_W-1:0] resolve(
    input logic [ROB_BIT-1:0] q, input logic [DAT_W-1:0] v,
    input logic rdy, input logic [DAT_W-1:0] val,
    input logic hit, input logic [DAT_W-1:0] cdb_v);
    if (q == '0)  return {{ROB_BIT{1'b0}}, v};
    else if (rdy) return {{ROB_BIT{1'b0}}, val};
    else if (hit) return {{ROB_BIT{1'b0}}, cdb_v};
    else          return {q, v};
  endfunction

`ifdef ROB_FLUSH_EN
  assign flush_fire = en & flush_i;
`else
  assign flush_fire = 1'b0;
`endif

  // Full check is made on pre-edge state, so a commit never frees a slot for the same edge.
  assign alloc_ready = (count_reg != CAP_TAG);
  assign alloc_fire  = en & ~flush_fire & bus.rf_en_i & alloc_ready;
  assign commit_fire = en & ~flush_fire & valid_reg[head_reg] & ready_reg[head_reg];
  assign wb_fire     = en & ~flush_fire & bus.cdb_en_i;

  assign bus.alloc_ready_o = alloc_ready;
  assign bus.alloc_id_o    = tail_reg;

  assign res_j = resolve(bus.rf_qj_i, bus.rf_vj_i, ready_reg[bus.rf_qj_i], value_mem[bus.rf_qj_i],
                         bus.cdb_en_i && (bus.cdb_q_i == bus.rf_qj_i), bus.cdb_v_i);
  assign res_k = resolve(bus.rf_qk_i, bus.rf_vk_i, ready_reg[bus.rf_qk_i], value_mem[bus.rf_qk_i],
                         bus.cdb_en_i && (bus.cdb_q_i == bus.rf_qk_i), bus.cdb_v_i);

  // Per-entry status: allocation overrides a stale CDB write to the same slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic hit_alloc, hit_wb, hit_commit;
      assign hit_alloc  = alloc_fire  && (tail_reg  == ROB_BIT'(gi));
      assign hit_wb     = wb_fire     && (bus.cdb_q_i == ROB_BIT'(gi));
      assign hit_commit = commit_fire && (head_reg  == ROB_BIT'(gi));
      assign valid_next[gi] = flush_fire ? 1'b0 : hit_alloc ? 1'b1 : hit_commit ? 1'b0 : valid_reg[gi];
      assign ready_next[gi] = flush_fire ? 1'b0 : hit_alloc ? 1'b0 : hit_wb ? 1'b1 : ready_reg[gi];
    end
  endgenerate

  // Pointer, occupancy and entry status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= ONE_TAG;
      tail_reg  <= ONE_TAG;
      count_reg <= '0;
      valid_reg <= '0;
      ready_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      ready_reg <= ready_next;
      if (flush_fire) begin
        head_reg  <= ONE_TAG;
        tail_reg  <= ONE_TAG;
        count_reg <= '0;
      end else begin
        if (alloc_fire)  tail_reg <= tag_inc(tail_reg);
        if (commit_fire) head_reg <= tag_inc(head_reg);
        case ({alloc_fire, commit_fire})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Entry payload storage; freed entries keep their data until reallocated.
  always_ff @(posedge clk) begin
    if (wb_fire)    value_mem[bus.cdb_q_i] <= bus.cdb_v_i;
    if (alloc_fire) rd_mem[tail_reg]       <= bus.rf_rd_i;
  end

  // Dispatch register: loaded on the allocating edge, pulse otherwise low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rs_en_o  <= 1'b0;
      bus.rs_qj_o  <= '0;
      bus.rs_qk_o  <= '0;
      bus.rs_vj_o  <= '0;
      bus.rs_vk_o  <= '0;
      bus.rs_qd_o  <= '0;
      bus.rs_op_o  <= '0;
      bus.rs_imm_o <= '0;
    end else begin
      bus.rs_en_o <= alloc_fire;
      if (alloc_fire) begin
        {bus.rs_qj_o, bus.rs_vj_o} <= res_j;
        {bus.rs_qk_o, bus.rs_vk_o} <= res_k;
        bus.rs_qd_o  <= bus.rf_qd_i;
        bus.rs_op_o  <= bus.rf_op_i;
        bus.rs_imm_o <= bus.rf_imm_i;
      end
    end
  end

  // Commit register: head entry retires when valid and ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rf_en_o <= 1'b0;
      bus.rf_rd_o <= '0;
      bus.rf_q_o  <= '0;
      bus.rf_v_o  <= '0;
    end else begin
      bus.rf_en_o <= commit_fire;
      if (commit_fire) begin
        bus.rf_rd_o <= rd_mem[head_reg];
        bus.rf_q_o  <= head_reg;
        bus.rf_v_o  <= value_mem[head_reg];
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a reference model pushes expected
// dispatch/commit packets into queues that are popped when the DUT pulses.
module tb_reorder_buffer;
  localparam int ROB_BIT = 4, REG_BIT = 5, DAT_W = 32, OP_W = 6;
  localparam int CAP = 15;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_BIT(ROB_BIT), .REG_BIT(REG_BIT), .DAT_W(DAT_W), .OP_W(OP_W)) bus ();

  reorder_buffer #(.ROB_BIT(ROB_BIT), .REG_BIT(REG_BIT), .DAT_W(DAT_W), .OP_W(OP_W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
`ifdef ROB_FLUSH_EN
    .flush_i(flush),
`endif
    .bus(bus)
  );

  int total = 0, bad = 0;
  logic [113:0] rs_q[$];
  logic [40:0]  cm_q[$];

  int m_head, m_tail, m_count;
  bit m_valid[16], m_ready[16];
  logic [31:0] m_val[16];
  logic [4:0]  m_rd[16];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int t);
    return (t == CAP) ? 1 : t + 1;
  endfunction

  function automatic logic [35:0] resolve(input int q, input logic [31:0] v);
    if (q == 0) return {4'd0, v};
    if (m_ready[q]) return {4'd0, m_val[q]};
    if (bus.cdb_en_i && int'(bus.cdb_q_i) == q) return {4'd0, bus.cdb_v_i};
    return {4'(q), v};
  endfunction

  task automatic model_reset();
    m_head = 1; m_tail = 1; m_count = 0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_ready[i] = 0;
    end
  endtask

  task automatic idle_inputs();
    bus.rf_en_i = 0; bus.rf_qd_i = '0; bus.rf_rd_i = '0;
    bus.rf_qj_i = '0; bus.rf_qk_i = '0; bus.rf_vj_i = '0; bus.rf_vk_i = '0;
    bus.rf_op_i = '0; bus.rf_imm_i = '0;
    bus.cdb_en_i = 0; bus.cdb_q_i = '0; bus.cdb_v_i = '0;
  endtask

  // One clock: model predicts from pre-edge state, then DUT outputs are compared.
  task automatic step();
    bit acc, com;
    logic [35:0] jr, kr;
    logic [113:0] exp_rs;
    logic [40:0]  exp_cm;
    check("alloc_ready", bus.alloc_ready_o, m_count < CAP);
    check("alloc_id", bus.alloc_id_o, m_tail);
    acc = 0; com = 0;
`ifdef ROB_FLUSH_EN
    if (en && flush) model_reset();
    else
`endif
    if (en) begin
      acc = bus.rf_en_i && (m_count < CAP);
      com = m_valid[m_head] && m_ready[m_head];
      if (acc) begin
        jr = resolve(bus.rf_qj_i, bus.rf_vj_i);
        kr = resolve(bus.rf_qk_i, bus.rf_vk_i);
        rs_q.push_back({jr[35:32], kr[35:32], jr[31:0], kr[31:0], 4'(m_tail), bus.rf_op_i, bus.rf_imm_i});
      end
      if (com) cm_q.push_back({m_rd[m_head], 4'(m_head), m_val[m_head]});
      if (bus.cdb_en_i) begin
        m_val[bus.cdb_q_i] = bus.cdb_v_i; m_ready[bus.cdb_q_i] = 1;
      end
      if (acc) begin
        m_rd[m_tail] = bus.rf_rd_i; m_valid[m_tail] = 1; m_ready[m_tail] = 0; m_tail = nxt(m_tail);
      end
      if (com) begin
        m_valid[m_head] = 0; m_head = nxt(m_head);
      end
      m_count = m_count + int'(acc) - int'(com);
    end
    @(posedge clk); #1;
    check("rs_en", bus.rs_en_o, acc);
    check("rf_en", bus.rf_en_o, com);
    if (acc) begin
      exp_rs = rs_q.pop_front();
      if (bus.rs_en_o)
        check("rs_pkt", {bus.rs_qj_o, bus.rs_qk_o, bus.rs_vj_o, bus.rs_vk_o, bus.rs_qd_o, bus.rs_op_o, bus.rs_imm_o}, exp_rs);
    end
    if (com) begin
      exp_cm = cm_q.pop_front();
      if (bus.rf_en_o) check("commit_pkt", {bus.rf_rd_o, bus.rf_q_o, bus.rf_v_o}, exp_cm);
    end
    $display("cyc en=%0b rs_en=%0b rf_en=%0b head=%0d tail=%0d count=%0d", en, bus.rs_en_o, bus.rf_en_o, m_head, m_tail, m_count);
  endtask

  task automatic set_issue(input int rd, input int qj, input logic [31:0] vj, input int qk, input logic [31:0] vk);
    bus.rf_en_i = 1; bus.rf_qd_i = 4'(m_tail); bus.rf_rd_i = 5'(rd);
    bus.rf_qj_i = 4'(qj); bus.rf_vj_i = vj; bus.rf_qk_i = 4'(qk); bus.rf_vk_i = vk;
    bus.rf_op_i = 6'($urandom); bus.rf_imm_i = $urandom;
  endtask

  task automatic set_cdb(input int q, input logic [31:0] v);
    bus.cdb_en_i = 1; bus.cdb_q_i = 4'(q); bus.cdb_v_i = v;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_alloc_id", bus.alloc_id_o, 1);
    check("rst_alloc_ready", bus.alloc_ready_o, 1);
    check("rst_rs_en", bus.rs_en_o, 0);
    check("rst_rf_en", bus.rf_en_o, 0);
    check("rst_rs_vj", bus.rs_vj_o, 0);
    check("rst_rf_v", bus.rf_v_o, 0);
    rst = 1; en = 1;

    // First issue: both operands valid.
    set_issue(3, 0, 5, 0, 7); step(); idle_inputs();
    check("t1_rs_qd", bus.rs_qd_o, 1);
    check("t1_rs_vj", bus.rs_vj_o, 5);
    check("t1_rs_vk", bus.rs_vk_o, 7);
    set_cdb(1, 32'h2A); step(); idle_inputs();
    step();
    check("t1_rf_en", bus.rf_en_o, 1);
    check("t1_rf_rd", bus.rf_rd_o, 3);
    check("t1_rf_q", bus.rf_q_o, 1);
    check("t1_rf_v", bus.rf_v_o, 32'h2A);
    check("t1_empty", bus.alloc_id_o, 2);

    // CDB bypass and pass-through.
    set_issue(4, 0, 1, 0, 2); step(); idle_inputs();
    set_issue(5, 2, 77, 0, 3); set_cdb(2, 9); step(); idle_inputs();
    check("byp_qj", bus.rs_qj_o, 0);
    check("byp_vj", bus.rs_vj_o, 9);
    set_issue(6, 3, 32'h55, 0, 4); step(); idle_inputs();
    check("nohit_qj", bus.rs_qj_o, 3);
    check("nohit_vj", bus.rs_vj_o, 32'h55);
    set_cdb(3, 100); step(); idle_inputs();
    set_issue(7, 3, 0, 2, 0); set_cdb(4, 200); step(); idle_inputs();
    set_cdb(5, 300); step(); idle_inputs();
    repeat (5) step();

    // Fill to capacity, then one extra request that must be dropped.
    for (int i = 0; i < CAP + 1; i++) begin
      set_issue(i + 1, $urandom_range(0, CAP), $urandom, 0, $urandom); step();
    end
    idle_inputs();
    check("full_ready", bus.alloc_ready_o, 0);
    set_cdb(m_head, 32'hBEEF); step(); idle_inputs();
    set_issue(9, 0, 1, 0, 1); step();
    set_issue(10, 0, 2, 0, 2); step(); idle_inputs();

    // Out-of-order completion with an en drop midway.
    set_cdb(nxt(m_head), 32'h22); step(); idle_inputs();
    set_cdb(m_head, 32'h11); step(); idle_inputs();
    step();
    en = 0; step(); en = 1;
    repeat (3) step();

    // Asynchronous reset mid-operation.
    rst = 0; #1;
    model_reset();
    check("mid_rst_id", bus.alloc_id_o, 1);
    check("mid_rst_rf_en", bus.rf_en_o, 0);
    @(posedge clk); #1;
    rst = 1;

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 4; i++) begin
      set_issue(i, 0, i, 0, i); step();
    end
    idle_inputs();
    set_cdb(1, 1); flush = 1; step(); flush = 0; idle_inputs();
    check("flush_id", bus.alloc_id_o, 1);
    repeat (3) step();
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1)
        set_issue($urandom_range(0, 31), ($urandom_range(0, 1) == 1) ? $urandom_range(1, CAP) : 0, $urandom,
                  ($urandom_range(0, 1) == 1) ? $urandom_range(1, CAP) : 0, $urandom);
      if ($urandom_range(0, 9) < 6) begin
        int s;
        s = $urandom_range(1, CAP);
        for (int i = 0; i < CAP; i++) begin
          int t;
          t = ((s - 1 + i) % CAP) + 1;
          if (m_valid[t] && !m_ready[t]) begin
            set_cdb(t, $urandom);
            break;
          end
        end
      end
      step();
    end
    idle_inputs(); en = 1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
